audio_src_fade_mux: RTL
=======================

// Module: audio_src_fade_mux
// PURPOSE
//  Selects one of NUM_SRC stereo sample sources and drives the audio_codec write port
//  (write, writedata_left/right). Generalises the two-task SW9 selector to N sources
//  with a per-source ready/valid handshake. Source changes go through a gain-ramped
//  fade-out/fade-in so switching never produces a click.
//  Sits between the task generators (mic loopback, ROM tone, ...) and audio_codec.
// PARAMETERS
//  DATA_W     24  sample width, signed two's complement
//  NUM_SRC    4   number of stereo sources (2..2**SEL_W)
//  SEL_W      2   width of sel / active_sel
//  FADE_BITS  4   gain resolution; FULL = 2**FADE_BITS, ramp length = FULL samples per direction
// PORTS
//  CLOCK_50        in   1                 system clock
//  reset           in   1                 synchronous, active-high
//  sel             in   SEL_W             requested source (from switches)
//  src_valid       in   NUM_SRC           source i has a sample pair
//  src_ready       out  NUM_SRC           source i pair consumed this cycle
//  src_left        in   NUM_SRC*DATA_W    source i left at [i*DATA_W +: DATA_W]
//  src_right       in   NUM_SRC*DATA_W    source i right, same packing
//  write_ready     in   1                 codec DAC FIFO has space
//  write           out  1                 one-cycle write strobe to codec
//  writedata_left  out  DATA_W            scaled left sample
//  writedata_right out  DATA_W            scaled right sample
//  active_sel      out  SEL_W             source currently routed
//  busy            out  1                 fade in progress (state != RUN)
// BEHAVIOUR
//  - Reset: write=0, writedata_*=0, active_sel=0, gain=FULL, state=RUN, busy=0.
//  - src_ready[i] = (i==active_sel) & src_valid[i] & write_ready; combinational. Other sources
//    are held (backpressured), never dropped.
//  - Transfer: the cycle src_ready[active_sel]=1. Next cycle: write=1 for exactly one cycle, with
//    writedata_* = (sample * gain) >>> FADE_BITS. Latency is 1 cycle. write=0 when no transfer.
//  - Arithmetic: signed DATA_W x unsigned (FADE_BITS+1) product, arithmetic right shift,
//    truncated to DATA_W. No overflow possible, since gain <= FULL. gain==FULL gives an exact pass-through.
//  - Gain is applied to the current sample first, then updated. It changes only on a transfer,
//    so a stalled source or write_ready=0 freezes the fade.
//  - sel values >= NUM_SRC are ignored (treated as equal to active_sel).
//  - FSM (with fade):
//    RUN:      gain=FULL. A valid sel != active_sel moves to FADE_OUT next cycle.
//    FADE_OUT: gain-=1 per transfer. When gain becomes 0: active_sel<=sel (value sampled that
//              cycle), go to FADE_IN. If sel returns to active_sel, go to FADE_IN at the current gain.
//    FADE_IN:  gain+=1 per transfer, reaching FULL -> RUN. A valid sel != active_sel goes to
//              FADE_OUT at the current gain (no jump).
//  - If sel changes repeatedly during FADE_OUT, only the value present when gain hits 0 is taken.
//  - Reset mid-fade aborts the fade immediately to the reset values. No write is issued the cycle after reset.
// CONFIGURATION
//  AUDIO_SRC_FADE_EN defined:   FSM and gain ramp as above.
//  AUDIO_SRC_FADE_EN undefined: no FSM, gain fixed at FULL, busy tied 0. A valid sel != active_sel
//    updates active_sel on the next clock edge. The following transfer comes from the new source
//    at full scale. The handshake and 1-cycle latency are unchanged.
// TESTING  (DATA_W=24, FADE_BITS=2 -> FULL=4, NUM_SRC=3, SEL_W=2, write_ready=1 unless stated)
//  1 Reset held 2 cycles with all sources valid -> write=0, writedata_*=0, active_sel=0,
//    busy=0, src_ready=0.
//  2 sel=0, src0 L=24'h100000 R=24'hF00000 valid -> src_ready[0]=1; next cycle write=1,
//    L=24'h100000, R=24'hF00000; src_ready[1]=src_ready[2]=0.
//  3 FADE_EN, src0=24'h040000, src1=24'h080000, sel 0->1 -> L sequence 040000,030000,020000,
//    010000, then 000000,020000,040000,060000,080000; busy high until RUN; active_sel=1 at switch.
//    Repeat with src0=24'hFC0000: the gain-3 output is 24'hFD0000.
//  4 write_ready=0 for 5 cycles mid-fade -> src_ready=0, write=0, gain and state frozen; the
//    sequence resumes unchanged after release.
//  5 sel=2'd3 (out of range) -> active_sel stays, no fade, outputs unchanged. Fade-out 0->1 with
//    sel back to 0 at gain 2 -> ramps up 2,3,4 from source 0; active_sel stays 0.
//  6 FADE_EN undefined, sel 0->2 -> active_sel=2 next cycle, first write from src2 at full scale,
//    busy=0 throughout. Reset asserted mid-fade (FADE_EN) -> reset values the next cycle.

Source files
------------

// File: rtl/audio_src_fade_mux.sv
// audio_src_fade_mux: routes one of NUM_SRC ready/valid stereo sources to the audio_codec write port.
// Define AUDIO_SRC_FADE_EN to ramp the gain down and back up around a source switch so it never clicks.
module audio_src_fade_mux #(
  parameter int DATA_W    = 24,
  parameter int NUM_SRC   = 4,
  parameter int SEL_W     = 2,
  parameter int FADE_BITS = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_left,
  input  logic [NUM_SRC*DATA_W-1:0] src_right,
  input  logic                      write_ready,
  output logic                      write,
  output logic [DATA_W-1:0]         writedata_left,
  output logic [DATA_W-1:0]         writedata_right,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      busy
);

  localparam int PROD_W = DATA_W + FADE_BITS + 2;
  localparam logic [FADE_BITS:0] FULL = {1'b1, {FADE_BITS{1'b0}}};

  logic [FADE_BITS:0]       gain;
  logic [DATA_W-1:0]        cur_left;
  logic [DATA_W-1:0]        cur_right;
  logic                     cur_valid;
  logic                     xfer;
  logic                     sel_ok;
  logic                     sel_new;
  logic signed [PROD_W-1:0] prod_left;
  logic signed [PROD_W-1:0] prod_right;
  logic [DATA_W-1:0]        scaled_left;
  logic [DATA_W-1:0]        scaled_right;

  // Only the routed source sees ready; every other source is held off, never dropped.
  always_comb begin
    cur_left  = '0;
    cur_right = '0;
    cur_valid = 1'b0;
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_sel == SEL_W'(i)) begin
        cur_left     = src_left[i*DATA_W +: DATA_W];
        cur_right    = src_right[i*DATA_W +: DATA_W];
        cur_valid    = src_valid[i];
        src_ready[i] = src_valid[i] & write_ready & ~reset;
      end
    end
  end

  assign xfer    = cur_valid & write_ready & ~reset;
  assign sel_ok  = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC));
  assign sel_new = sel_ok & (sel != active_sel);

  // Signed sample times non-negative gain; gain <= FULL so the shifted result always fits.
  assign prod_left    = PROD_W'($signed(cur_left))  * $signed(PROD_W'({1'b0, gain}));
  assign prod_right   = PROD_W'($signed(cur_right)) * $signed(PROD_W'({1'b0, gain}));
  assign scaled_left  = DATA_W'(prod_left  >>> FADE_BITS);
  assign scaled_right = DATA_W'(prod_right >>> FADE_BITS);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      write           <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
    end else begin
      write <= xfer;
      if (xfer) begin
        writedata_left  <= scaled_left;
        writedata_right <= scaled_right;
      end
    end
  end

`ifdef AUDIO_SRC_FADE_EN
  localparam logic [FADE_BITS:0] ONE     = {{FADE_BITS{1'b0}}, 1'b1};
  localparam logic [FADE_BITS:0] FULL_M1 = {1'b0, {FADE_BITS{1'b1}}};

  typedef enum logic [1:0] {RUN, FADE_OUT, FADE_IN} fade_state_t;
  fade_state_t state;

  // Gain moves only on a transfer, so backpressure or a stalled source freezes the ramp.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= RUN;
      gain       <= FULL;
      active_sel <= '0;
    end else begin
      case (state)
        RUN: begin
          gain <= FULL;
          if (sel_new) state <= FADE_OUT;
        end
        FADE_OUT: begin
          if (xfer && gain != '0) gain <= gain - 1'b1;
          if (gain == '0 || (xfer && gain == ONE)) begin
            if (sel_ok) active_sel <= sel;
            state <= FADE_IN;
          end else if (!sel_new) begin
            state <= FADE_IN;
          end
        end
        FADE_IN: begin
          if (xfer && gain != FULL) gain <= gain + 1'b1;
          if (sel_new) state <= FADE_OUT;
          else if (gain == FULL || (xfer && gain == FULL_M1)) state <= RUN;
        end
        default: begin
          state <= RUN;
          gain  <= FULL;
        end
      endcase
    end
  end

  assign busy = (state != RUN);
`else
  assign gain = FULL;
  assign busy = 1'b0;

  always_ff @(posedge CLOCK_50) begin
    if (reset) active_sel <= '0;
    else if (sel_new) active_sel <= sel;
  end
`endif

endmodule
